// File: rtl/instr_fetch_unit.sv
// Instruction fetch responder: issues one request at a time to a variable-latency
// instruction memory and registers the returned word into the IF/ID handoff.
module instr_fetch_unit #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_in,
  output logic        pc_stall,
  input  logic        id_stall,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc,
  output logic        instr_valid
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_HOLD,
    S_DRAIN
  } state_e;

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pc;
  } fetch_t;

  state_e      state_q, state_d;
  logic [31:0] req_pc_q, req_pc_d;
  fetch_t      out_q, out_d;
  logic        out_valid_q, out_valid_d;
  fetch_t      skid_q, skid_d;
  logic        outstanding;

  // A request is still in flight if it was issued this cycle or its data has not returned.
  assign outstanding = (state_q == S_ISSUE) ||
                       (((state_q == S_WAIT) || (state_q == S_DRAIN)) && !imem_rvalid);

  assign imem_req    = (state_q == S_ISSUE);
  assign imem_addr   = pc_in;
  assign instr_out   = out_q.word;
  assign instr_pc    = out_q.pc;
  assign instr_valid = out_valid_q;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_d     = state_q;
    req_pc_d    = req_pc_q;
    out_d       = out_q;
    out_valid_d = out_valid_q & id_stall;
    skid_d      = skid_q;
    pc_stall    = 1'b1;

    if (flush) begin
      pc_stall    = 1'b0;
      out_valid_d = 1'b0;
      out_d.word  = NOP_INSTR;
      skid_d      = '0;
      state_d     = outstanding ? S_DRAIN : S_ISSUE;
    end else begin
      unique case (state_q)
        S_IDLE: state_d = S_ISSUE;
        S_ISSUE: begin
          req_pc_d = pc_in;
          state_d  = S_WAIT;
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            if (!out_valid_q || !id_stall) begin
              out_d       = '{word: imem_rdata, pc: req_pc_q};
              out_valid_d = 1'b1;
              pc_stall    = 1'b0;
              state_d     = S_ISSUE;
            end else begin
              skid_d  = '{word: imem_rdata, pc: req_pc_q};
              state_d = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (!id_stall) begin
            out_d       = skid_q;
            out_valid_d = 1'b1;
            pc_stall    = 1'b0;
            state_d     = S_ISSUE;
          end
        end
        S_DRAIN: begin
          if (imem_rvalid) state_d = S_ISSUE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      req_pc_q    <= '0;
      out_q       <= '{word: NOP_INSTR, pc: 32'h0};
      out_valid_q <= 1'b0;
      skid_q      <= '0;
    end else begin
      state_q     <= state_d;
      req_pc_q    <= req_pc_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      skid_q      <= skid_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: PC and variable-latency memory models drive
// the fetch unit while a linear sequence checks its outputs at hand-derived cycles.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_in = 32'h0;
  logic        pc_stall;
  logic        id_stall;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic        instr_valid;

  int          total = 0;
  int          bad = 0;
  int          mem_lat = 1;
  int          cnt = 0;
  int          overlap = 0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] pend_addr = 32'h0;
  logic        stall_s = 1'b1;
  logic        flush_s = 1'b0;
  logic        req_s = 1'b0;
  logic [31:0] addr_s = 32'h0;

  instr_fetch_unit dut (
    .clk        (clk),
    .reset      (reset),
    .pc_in      (pc_in),
    .pc_stall   (pc_stall),
    .id_stall   (id_stall),
    .flush      (flush),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .instr_out  (instr_out),
    .instr_pc   (instr_pc),
    .instr_valid(instr_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h0050_0093;
      32'h4:   return 32'h0010_0113;
      32'h8:   return 32'h0020_0193;
      32'hC:   return 32'hDEAD_BEEF;
      32'h100: return 32'h0030_0213;
      default: return {16'hC0DE, a[15:0]};
    endcase
  endfunction

  always @(negedge clk) begin
    stall_s = pc_stall;
    flush_s = flush;
    req_s   = imem_req;
    addr_s  = imem_addr;
  end

  // PC and memory models update just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (!stall_s) pc_in = flush_s ? redirect_pc : pc_in + 32'd4;
    imem_rvalid = 1'b0;
    if (req_s && cnt != 0) overlap++;
    if (cnt != 0) begin
      cnt--;
      if (cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = word_at(pend_addr);
      end
    end
    if (req_s) begin
      pend_addr = addr_s;
      if (mem_lat == 1) begin
        imem_rvalid = 1'b1;
        imem_rdata  = word_at(addr_s);
      end else begin
        cnt = mem_lat - 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset    = 1'b0;
    id_stall = 1'b0;
    flush    = 1'b0;
    repeat (3) tick();
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_pc_stall", {31'd0, pc_stall}, 32'd1);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_out", instr_out, 32'h0000_0013);
    check("rst_pc", instr_pc, 32'h0);

    reset = 1'b1;
    #1;
    check("idle_req", {31'd0, imem_req}, 32'd0);
    tick();
    check("first_req", {31'd0, imem_req}, 32'd1);
    check("first_addr", imem_addr, 32'h0);
    check("issue_stall", {31'd0, pc_stall}, 32'd1);
    tick();
    check("first_rvalid", {31'd0, imem_rvalid}, 32'd1);
    check("rvalid_stall_low", {31'd0, pc_stall}, 32'd0);
    check("wait_valid", {31'd0, instr_valid}, 32'd0);
    tick();
    check("first_out", instr_out, 32'h0050_0093);
    check("first_pc", instr_pc, 32'h0);
    check("first_valid", {31'd0, instr_valid}, 32'd1);
    check("second_req", {31'd0, imem_req}, 32'd1);
    check("second_addr", imem_addr, 32'h4);

    mem_lat = 3;
    tick();
    check("w1_stall", {31'd0, pc_stall}, 32'd1);
    check("consumed", {31'd0, instr_valid}, 32'd0);
    tick();
    check("w2_stall", {31'd0, pc_stall}, 32'd1);
    check("w2_req", {31'd0, imem_req}, 32'd0);
    tick();
    check("w3_stall", {31'd0, pc_stall}, 32'd0);
    tick();
    check("seq_out4", instr_out, 32'h0010_0113);
    check("seq_pc4", instr_pc, 32'h4);
    check("seq_req8", {31'd0, imem_req}, 32'd1);
    check("seq_addr8", imem_addr, 32'h8);

    id_stall = 1'b1;
    repeat (3) tick();
    check("park_rvalid", {31'd0, imem_rvalid}, 32'd1);
    check("park_stall", {31'd0, pc_stall}, 32'd1);
    check("park_out", instr_out, 32'h0010_0113);
    tick();
    check("hold_stall", {31'd0, pc_stall}, 32'd1);
    check("hold_out", instr_out, 32'h0010_0113);
    check("hold_valid", {31'd0, instr_valid}, 32'd1);
    check("hold_req", {31'd0, imem_req}, 32'd0);
    id_stall = 1'b0;
    #1;
    check("hold_release", {31'd0, pc_stall}, 32'd0);
    tick();
    check("skid_out", instr_out, 32'h0020_0193);
    check("skid_pc", instr_pc, 32'h8);
    check("skid_valid", {31'd0, instr_valid}, 32'd1);
    check("after_skid_req", {31'd0, imem_req}, 32'd1);
    check("after_skid_addr", imem_addr, 32'hC);

    tick();
    redirect_pc = 32'h100;
    flush = 1'b1;
    #1;
    check("flush_stall", {31'd0, pc_stall}, 32'd0);
    tick();
    flush = 1'b0;
    #1;
    check("flush_valid", {31'd0, instr_valid}, 32'd0);
    check("flush_nop", instr_out, 32'h0000_0013);
    check("drain_req", {31'd0, imem_req}, 32'd0);
    check("drain_stall", {31'd0, pc_stall}, 32'd1);
    tick();
    check("stale_rvalid", {31'd0, imem_rvalid}, 32'd1);
    check("stale_stall", {31'd0, pc_stall}, 32'd1);
    tick();
    check("redir_req", {31'd0, imem_req}, 32'd1);
    check("redir_addr", imem_addr, 32'h100);
    check("stale_dropped", instr_out, 32'h0000_0013);
    check("stale_not_valid", {31'd0, instr_valid}, 32'd0);
    repeat (4) tick();
    check("redir_out", instr_out, 32'h0030_0213);
    check("redir_pc", instr_pc, 32'h100);

    mem_lat = 1;
    tick();
    check("coinc_rvalid", {31'd0, imem_rvalid}, 32'd1);
    redirect_pc = 32'h200;
    flush = 1'b1;
    #1;
    check("coinc_stall", {31'd0, pc_stall}, 32'd0);
    tick();
    flush = 1'b0;
    #1;
    check("coinc_no_drain", {31'd0, imem_req}, 32'd1);
    check("coinc_addr", imem_addr, 32'h200);
    check("coinc_nop", instr_out, 32'h0000_0013);
    check("coinc_valid", {31'd0, instr_valid}, 32'd0);

    mem_lat = 3;
    tick();
    reset = 1'b0;
    #1;
    check("async_pc", instr_pc, 32'h0);
    check("async_stall", {31'd0, pc_stall}, 32'd1);
    check("async_req", {31'd0, imem_req}, 32'd0);
    repeat (2) tick();
    check("rst_rvalid", {31'd0, imem_rvalid}, 32'd1);
    check("rst_ignore_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_ignore_out", instr_out, 32'h0000_0013);
    tick();
    reset = 1'b1;
    tick();
    check("restart_req", {31'd0, imem_req}, 32'd1);
    check("restart_addr", imem_addr, 32'h200);
    repeat (4) tick();
    check("restart_out", instr_out, 32'hC0DE_0200);
    check("restart_pc", instr_pc, 32'h200);
    check("restart_valid", {31'd0, instr_valid}, 32'd1);
    check("one_outstanding", overlap, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
